// File: rtl/fifo_sync_param_if.sv
// ---------------------------------------------------------------------------
// fifo_sync_param_if
// Bundles the FIFO request and status signals.
//   master : drives push/wr_data/pop/flush and observes data and status
//            (the FIFO user).
//   slave  : the FIFO itself.
// Signals:
//   push, wr_data  write request and data
//   pop            read request
//   flush          synchronous clear
//   rd_data        read data
//   rd_valid       read data qualifier
//   full, empty, almost_full, almost_empty, count
//                  registered occupancy status
//   overflow       sticky: a push was dropped
//   underflow      sticky: a pop was ignored
// ---------------------------------------------------------------------------
interface fifo_sync_param_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic [WIDTH-1:0] wr_data;
    logic             pop;
    logic             flush;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, wr_data, pop, flush,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  push, wr_data, pop, flush,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
// Parametrised single-clock FIFO with a flop-array store, registered
// occupancy flags, sticky overflow/underflow, synchronous flush and an
// optional first-word-fall-through read port.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    fifo_sync_param_if.slave (requests in, data/status out)
// Parameters:
//   WIDTH      data width
//   DEPTH      entries, power of 2, >= 2
//   AF_THRESH  almost_full when count >= AF_THRESH
//   AE_THRESH  almost_empty when count <= AE_THRESH
//   FWFT       0 = registered read, 1 = first-word fall-through
// ---------------------------------------------------------------------------
module fifo_sync_param #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input logic              clk,
    input logic              reset,
    fifo_sync_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fifo_sync_param: DEPTH must be a power of 2 and >= 2");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH - 1) begin : g_bad_af
            $error("fifo_sync_param: AF_THRESH must lie in 1..DEPTH-1");
        end
        if (AE_THRESH < 1 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
            $error("fifo_sync_param: AE_THRESH must lie in 1..DEPTH-1");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("fifo_sync_param: WIDTH must be >= 1");
        end
    endgenerate

    // Reset asserts asynchronously; release is retimed to clk so all state
    // leaves reset on the same edge.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    logic             full_q;
    logic             empty_q;
    logic             almost_full_q;
    logic             almost_empty_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             full_nxt;
    logic             empty_nxt;
    logic             push_accept;
    logic             pop_accept;
    logic             push_drop;
    logic             pop_drop;

    assign wr_addr = wr_ptr[AW-1:0];
    assign rd_addr = rd_ptr[AW-1:0];

    // A full FIFO still takes a push when a pop frees a slot in the same
    // cycle; an empty FIFO never lets a pop through, so there is no bypass.
    assign pop_accept  = bus.pop && !empty_q && !bus.flush;
    assign push_accept = bus.push && (!full_q || pop_accept) && !bus.flush;
    assign push_drop   = bus.push && full_q && !pop_accept && !bus.flush;
    assign pop_drop    = bus.pop && empty_q && !bus.flush;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count_q;
        if (bus.flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (push_accept) begin
                wr_ptr_nxt = wr_ptr + 1'b1;
            end
            if (pop_accept) begin
                rd_ptr_nxt = rd_ptr + 1'b1;
            end
            count_nxt = count_q + {{(CW-1){1'b0}}, push_accept}
                                - {{(CW-1){1'b0}}, pop_accept};
        end
    end

    // Same address with differing wrap bits means the writer is a full lap
    // ahead of the reader.
    assign empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    assign full_nxt  = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                       (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            count_q        <= count_nxt;
            full_q         <= full_nxt;
            empty_q        <= empty_nxt;
            almost_full_q  <= (count_nxt >= CW'(AF_THRESH));
            almost_empty_q <= (count_nxt <= CW'(AE_THRESH));
            if (bus.flush) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end else begin
                if (push_drop) begin
                    overflow_q <= 1'b1;
                end
                if (pop_drop) begin
                    underflow_q <= 1'b1;
                end
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_accept && rst_int_n) begin
            mem[wr_addr] <= bus.wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rd_data  = mem[rd_addr];
            assign bus.rd_valid = !empty_q;
        end else begin : g_std
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;

            always_ff @(posedge clk or negedge rst_int_n) begin
                if (!rst_int_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= pop_accept;
                    if (pop_accept) begin
                        rd_data_q <= mem[rd_addr];
                    end
                end
            end

            assign bus.rd_data  = rd_data_q;
            assign bus.rd_valid = rd_valid_q;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_param
// Directed bench for fifo_sync_param: one standard-mode instance and one
// FWFT instance, both 8 x 64, each with its own reset.
// ---------------------------------------------------------------------------
module tb_fifo_sync_param;
    logic clk;
    logic reset0;
    logic reset1;
    int   errors;
    int   checks;

    fifo_sync_param_if #(.WIDTH(64), .DEPTH(8)) bus0 ();
    fifo_sync_param_if #(.WIDTH(64), .DEPTH(8)) bus1 ();

    fifo_sync_param #(.WIDTH(64), .DEPTH(8), .FWFT(0)) dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (bus0.slave)
    );

    fifo_sync_param #(.WIDTH(64), .DEPTH(8), .FWFT(1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [63:0] q[$];
        logic [63:0] exp_word;
        errors = 0;
        checks = 0;
        reset0 = 1'b0;
        reset1 = 1'b0;
        bus0.push = 1'b0; bus0.pop = 1'b0; bus0.flush = 1'b0; bus0.wr_data = '0;
        bus1.push = 1'b0; bus1.pop = 1'b0; bus1.flush = 1'b0; bus1.wr_data = '0;

        tick();
        tick();
        check("rst_empty", bus0.empty, 1'b1);
        check("rst_full", bus0.full, 1'b0);
        check("rst_count", bus0.count, 0);
        check("rst_ae", bus0.almost_empty, 1'b1);
        check("rst_af", bus0.almost_full, 1'b0);
        check("rst_rd_data", bus0.rd_data, 0);
        check("rst_rd_valid", bus0.rd_valid, 1'b0);

        reset0 = 1'b1;
        reset1 = 1'b1;
        repeat (4) tick();
        check("idle_empty", bus0.empty, 1'b1);
        check("idle_count", bus0.count, 0);
        check("idle_ovf", bus0.overflow, 1'b0);
        check("idle_udf", bus0.underflow, 1'b0);
        check("idle_ae", bus0.almost_empty, 1'b1);

        // Fill with 1..8.
        for (int i = 0; i < 8; i++) begin
            bus0.push = 1'b1;
            bus0.wr_data = 64'(i + 1);
            tick();
            check("fill_count", bus0.count, 64'(i + 1));
            check("fill_af", bus0.almost_full, (i + 1) >= 6);
            check("fill_ae", bus0.almost_empty, (i + 1) <= 2);
            check("fill_full", bus0.full, (i + 1) == 8);
            check("fill_empty", bus0.empty, 1'b0);
        end

        // Push into a full FIFO: dropped, overflow sticks.
        bus0.wr_data = 64'hDEAD;
        tick();
        bus0.push = 1'b0;
        check("ovf_set", bus0.overflow, 1'b1);
        check("ovf_count", bus0.count, 8);
        tick();
        check("ovf_sticky", bus0.overflow, 1'b1);
        check("ovf_rd_valid", bus0.rd_valid, 1'b0);

        // Drain: original words only, one cycle after each pop.
        for (int i = 0; i < 8; i++) begin
            bus0.pop = 1'b1;
            tick();
            check("drain_valid", bus0.rd_valid, 1'b1);
            check("drain_data", bus0.rd_data, 64'(i + 1));
            check("drain_count", bus0.count, 64'(7 - i));
        end
        bus0.pop = 1'b0;
        tick();
        check("drain_valid_off", bus0.rd_valid, 1'b0);
        check("drain_hold", bus0.rd_data, 64'h8);
        check("drain_empty", bus0.empty, 1'b1);
        check("drain_ovf_still", bus0.overflow, 1'b1);

        bus0.flush = 1'b1;
        tick();
        bus0.flush = 1'b0;
        check("flush_ovf", bus0.overflow, 1'b0);
        check("flush_count", bus0.count, 0);

        // Refill, then push+pop while full across pointer wrap.
        for (int i = 0; i < 8; i++) begin
            bus0.push = 1'b1;
            bus0.wr_data = 64'h10 + 64'(i);
            q.push_back(64'h10 + 64'(i));
            tick();
        end
        check("refill_full", bus0.full, 1'b1);
        bus0.pop = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus0.wr_data = 64'h100 + 64'(k);
            q.push_back(64'h100 + 64'(k));
            exp_word = q.pop_front();
            tick();
            check("pp_valid", bus0.rd_valid, 1'b1);
            check("pp_data", bus0.rd_data, exp_word);
            check("pp_count", bus0.count, 8);
            check("pp_ovf", bus0.overflow, 1'b0);
        end
        bus0.push = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_word = q.pop_front();
            tick();
            check("wrap_data", bus0.rd_data, exp_word);
        end
        bus0.pop = 1'b0;
        tick();
        check("wrap_empty", bus0.empty, 1'b1);

        // Pop on empty.
        bus0.pop = 1'b1;
        tick();
        bus0.pop = 1'b0;
        check("udf_set", bus0.underflow, 1'b1);
        check("udf_rd_valid", bus0.rd_valid, 1'b0);
        check("udf_count", bus0.count, 0);

        // Push+pop on empty: push taken, no bypass.
        bus0.push = 1'b1;
        bus0.pop = 1'b1;
        bus0.wr_data = 64'h77;
        tick();
        bus0.push = 1'b0;
        bus0.pop = 1'b0;
        check("epp_count", bus0.count, 1);
        check("epp_rd_valid", bus0.rd_valid, 1'b0);
        check("epp_udf", bus0.underflow, 1'b1);

        // Flush beats a concurrent push and pop.
        bus0.flush = 1'b1;
        bus0.push = 1'b1;
        bus0.pop = 1'b1;
        tick();
        bus0.flush = 1'b0;
        bus0.push = 1'b0;
        bus0.pop = 1'b0;
        check("fl_udf", bus0.underflow, 1'b0);
        check("fl_ovf", bus0.overflow, 1'b0);
        check("fl_count", bus0.count, 0);
        check("fl_empty", bus0.empty, 1'b1);
        check("fl_rd_valid", bus0.rd_valid, 1'b0);

        // FWFT instance.
        check("fw_idle_valid", bus1.rd_valid, 1'b0);
        bus1.push = 1'b1;
        bus1.wr_data = 64'hA5;
        tick();
        bus1.push = 1'b0;
        check("fw_valid", bus1.rd_valid, 1'b1);
        check("fw_data", bus1.rd_data, 64'hA5);
        tick();
        check("fw_hold", bus1.rd_data, 64'hA5);
        bus1.pop = 1'b1;
        tick();
        bus1.pop = 1'b0;
        check("fw_pop_empty", bus1.empty, 1'b1);
        check("fw_pop_valid", bus1.rd_valid, 1'b0);

        for (int i = 0; i < 5; i++) begin
            bus1.push = 1'b1;
            bus1.wr_data = 64'hB0 + 64'(i);
            tick();
        end
        bus1.push = 1'b0;
        check("fw_count5", bus1.count, 5);
        check("fw_head", bus1.rd_data, 64'hB0);
        bus1.pop = 1'b1;
        tick();
        bus1.pop = 1'b0;
        check("fw_next", bus1.rd_data, 64'hB1);
        check("fw_count4", bus1.count, 4);

        // Asynchronous reset mid-stream, checked before any clock edge.
        #2;
        reset1 = 1'b0;
        #1;
        check("fw_async_count", bus1.count, 0);
        check("fw_async_empty", bus1.empty, 1'b1);
        check("fw_async_valid", bus1.rd_valid, 1'b0);
        tick();
        reset1 = 1'b1;
        repeat (3) tick();
        check("fw_after_rst", bus1.count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
